// File: rtl/spi_master_gen.sv
// SPI master: one DATA_W-bit full-duplex word per txstart, programmable SCK divider,
// all four CPOL/CPHA modes, MSB/LSB-first, one-hot chip selects with optional hold.
// Optional feature: define SPI_LOOPBACK_EN to add the loopback input port.
module spi_master_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8,
  parameter int unsigned NUM_CS = 2,
  localparam int unsigned CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] txdata,
  input  logic              txstart,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  div,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic              cs_hold,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic [DATA_W-1:0] rxdata,
  output logic              rxvalid,
  output logic              busy,
  output logic              spi_sck,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int unsigned EdgeW = $clog2(2 * DATA_W) + 1;
  localparam logic [EdgeW-1:0] LastEdge = EdgeW'(2 * DATA_W);

  typedef enum logic [1:0] {StIdle, StSetup, StShift, StHold} state_e;

  state_e            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
  logic              cpol_q, cpol_d, cpha_q, cpha_d;
  logic              lsb_q, lsb_d, hold_q, hold_d;
  logic [NUM_CS-1:0] cs_oh_q, cs_oh_d, cs_n_q, cs_n_d, cs_dec;
  logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, rxdata_q, rxdata_d, tx_shift;
  logic [EdgeW-1:0]  edge_q, edge_d, edge_n;
  logic              rxvalid_q, rxvalid_d, busy_q, busy_d;
  logic              sck_q, sck_d, mosi_q, mosi_d;
  logic              loop_en, miso_s, tick, lead;

`ifdef SPI_LOOPBACK_EN
  assign loop_en = loopback;
`else
  assign loop_en = 1'b0;
`endif

  function automatic logic head_bit(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? v[0] : v[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] v, input logic lsb);
    return lsb ? (v >> 1) : (v << 1);
  endfunction

  always_comb begin
    cs_dec = '0;
    for (int unsigned i = 0; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) cs_dec[i] = 1'b1;
    end
  end

  assign tick     = (cnt_q == '0);
  assign miso_s   = loop_en ? mosi_q : spi_miso;
  assign edge_n   = edge_q + EdgeW'(1);
  assign lead     = edge_n[0];  // odd-numbered edges are leading edges
  assign tx_shift = shift_out(tx_q, lsb_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    div_d     = div_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    hold_d    = hold_q;
    cs_oh_d   = cs_oh_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    rxdata_d  = rxdata_q;
    edge_d    = edge_q;
    rxvalid_d = 1'b0;
    busy_d    = busy_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;

    case (state_q)
      StIdle: begin
        sck_d  = cpol_q;
        mosi_d = 1'b0;
        if (txstart) begin
          state_d = StSetup;
          cnt_d   = div;
          div_d   = div;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          hold_d  = cs_hold;
          cs_oh_d = cs_dec;
          tx_d    = txdata;
          rx_d    = '0;
          edge_d  = '0;
          busy_d  = 1'b1;
          sck_d   = cpol;
          mosi_d  = cpha ? 1'b0 : head_bit(txdata, lsb_first);
        end
      end
      StSetup, StShift: begin
        if (tick) begin
          cnt_d  = div_q;
          edge_d = edge_n;
          sck_d  = cpol_q ^ lead;
          if (lead != cpha_q) begin
            rx_d = lsb_q ? {miso_s, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], miso_s};
          end
          // CPHA=1 shows bit 0 on edge 1 without shifting; the final edge never advances
          if ((lead == cpha_q) && (edge_n != LastEdge)) begin
            if (edge_n == EdgeW'(1)) begin
              mosi_d = head_bit(tx_q, lsb_q);
            end else begin
              tx_d   = tx_shift;
              mosi_d = head_bit(tx_shift, lsb_q);
            end
          end
          state_d = (edge_n == LastEdge) ? StHold : StShift;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      StHold: begin
        if (tick) begin
          state_d   = StIdle;
          busy_d    = 1'b0;
          rxvalid_d = 1'b1;
          rxdata_d  = rx_q;
          mosi_d    = 1'b0;
          sck_d     = cpol_q;
          if (!hold_q) cs_oh_d = '0;
        end else begin
          cnt_d = cnt_q - DIV_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Loopback keeps the bus pins quiet while the internal transfer runs
    if (loop_en) sck_d = cpol_d;
    cs_n_d = loop_en ? '1 : ~cs_oh_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      div_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      hold_q    <= 1'b0;
      cs_oh_q   <= '0;
      cs_n_q    <= '1;
      tx_q      <= '0;
      rx_q      <= '0;
      rxdata_q  <= '0;
      edge_q    <= '0;
      rxvalid_q <= 1'b0;
      busy_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      hold_q    <= hold_d;
      cs_oh_q   <= cs_oh_d;
      cs_n_q    <= cs_n_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      rxdata_q  <= rxdata_d;
      edge_q    <= edge_d;
      rxvalid_q <= rxvalid_d;
      busy_q    <= busy_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
    end
  end

  assign rxdata   = rxdata_q;
  assign rxvalid  = rxvalid_q;
  assign busy     = busy_q;
  assign spi_sck  = sck_q;
  assign spi_mosi = mosi_q;
  assign spi_cs_n = cs_n_q;

endmodule
